// File: rtl/softusb_timer_sched.sv
// Frame sequencer and IO arbiter between the Navre CPU and softusb_timer.
// Timer0 becomes a periodic USB frame tick while the sequencer is enabled.
module softusb_timer_sched #(
   parameter logic [5:0]  TMR_CTRL_ADDR = 6'h20,
   parameter logic [5:0]  TMR_CMPL_ADDR = 6'h21,
   parameter logic [5:0]  TMR_CMPH_ADDR = 6'h22,
   parameter logic [7:0]  CTRL_RUN      = 8'h13,
   parameter logic [5:0]  SCHED_BASE    = 6'h28,
   parameter logic [15:0] PERIOD_RST    = 16'd47999
) (
   input  logic        usb_clk,
   input  logic        usb_rst_n,
   input  logic        cpu_io_we,
   input  logic [5:0]  cpu_io_a,
   input  logic [7:0]  cpu_io_di,
   output logic [7:0]  cpu_io_do,
   output logic [1:0]  cpu_irq,
   input  logic [1:0]  cpu_irq_ack,
   output logic        tmr_io_we,
   output logic [5:0]  tmr_io_a,
   output logic [7:0]  tmr_io_di,
   input  logic [7:0]  tmr_io_do,
   input  logic [1:0]  tmr_irq,
   output logic [1:0]  tmr_irq_ack,
   output logic        sof,
   output logic [10:0] frame_no
);

   typedef enum logic [2:0] {
      IDLE, PROG_L, PROG_H, PROG_C, RUN, STOP
   } state_t;

   state_t state, state_d;

   logic        en, blocked, reprog;
   logic [15:0] period;
   logic [10:0] frame_cnt;
   logic        pend_v;
   logic [5:0]  pend_a;
   logic [7:0]  pend_d;
   logic        irq0_q, sof_q, ack_q;

   logic        sel_ctrl, sel_perl, sel_perh;
   logic        sel_frml, sel_frmh, sched_hit;
   logic        tmr0_hit, cpu_blk, cpu_fwd;
   logic        wr_ctrl, wr_perl, wr_perh;
   logic        pend_issue, irq0_rise, in_run;
   logic        seq_load;
   logic [5:0]  seq_a;
   logic [7:0]  seq_d;

   assign sel_ctrl  = cpu_io_a == SCHED_BASE;
   assign sel_perl  = cpu_io_a == SCHED_BASE + 6'd1;
   assign sel_perh  = cpu_io_a == SCHED_BASE + 6'd2;
   assign sel_frml  = cpu_io_a == SCHED_BASE + 6'd3;
   assign sel_frmh  = cpu_io_a == SCHED_BASE + 6'd4;
   assign sched_hit = sel_ctrl | sel_perl | sel_perh
                    | sel_frml | sel_frmh;

   assign tmr0_hit = (cpu_io_a == TMR_CTRL_ADDR)
                   | (cpu_io_a == TMR_CMPL_ADDR)
                   | (cpu_io_a == TMR_CMPH_ADDR);

   // Timer0 belongs to the sequencer while enabled.
   assign cpu_blk = cpu_io_we & ~sched_hit & tmr0_hit & en;
   assign cpu_fwd = cpu_io_we & ~sched_hit & ~cpu_blk;

   assign wr_ctrl = cpu_io_we & sel_ctrl;
   assign wr_perl = cpu_io_we & sel_perl;
   assign wr_perh = cpu_io_we & sel_perh;

   assign pend_issue = pend_v & ~cpu_io_we;
   assign irq0_rise  = tmr_irq[0] & ~irq0_q;
   assign in_run     = state == RUN;

   always_comb begin
      state_d  = state;
      seq_load = 1'b0;
      seq_a    = 6'h00;
      seq_d    = 8'h00;
      unique case (state)
         IDLE: begin
            if (en) state_d = PROG_L;
         end
         PROG_L: begin
            if (!pend_v) begin
               seq_load = 1'b1;
               seq_a    = TMR_CMPL_ADDR;
               seq_d    = period[7:0];
               state_d  = en ? PROG_H : STOP;
            end
         end
         PROG_H: begin
            if (!pend_v) begin
               seq_load = 1'b1;
               seq_a    = TMR_CMPH_ADDR;
               seq_d    = period[15:8];
               state_d  = en ? PROG_C : STOP;
            end
         end
         PROG_C: begin
            if (!pend_v) begin
               seq_load = 1'b1;
               seq_a    = TMR_CTRL_ADDR;
               seq_d    = CTRL_RUN;
               state_d  = en ? RUN : STOP;
            end
         end
         RUN: begin
            if (!en)
               state_d = STOP;
            else if (reprog)
               state_d = PROG_L;
         end
         STOP: begin
            if (!pend_v) begin
               seq_load = 1'b1;
               seq_a    = TMR_CTRL_ADDR;
               seq_d    = 8'h00;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge usb_clk or negedge usb_rst_n) begin
      if (!usb_rst_n) begin
         state     <= IDLE;
         en        <= 1'b0;
         blocked   <= 1'b0;
         reprog    <= 1'b0;
         period    <= PERIOD_RST;
         frame_cnt <= 11'd0;
         pend_v    <= 1'b0;
         pend_a    <= 6'h00;
         pend_d    <= 8'h00;
         irq0_q    <= 1'b0;
         sof_q     <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state  <= state_d;
         irq0_q <= tmr_irq[0];
         sof_q  <= irq0_rise & in_run;
         ack_q  <= irq0_rise & (state != IDLE);

         if (wr_ctrl) begin
            en <= cpu_io_di[0];
            if (cpu_io_di[1]) blocked <= 1'b0;
         end else if (cpu_blk) begin
            blocked <= 1'b1;
         end

         if (wr_perl) period[7:0]  <= cpu_io_di;
         if (wr_perh) period[15:8] <= cpu_io_di;

         if ((wr_perl | wr_perh) && state != IDLE)
            reprog <= 1'b1;
         else if (state_d == PROG_L && state != PROG_L)
            reprog <= 1'b0;

         if (wr_ctrl && cpu_io_di[0] && !en)
            frame_cnt <= 11'd0;
         else if (irq0_rise && in_run)
            frame_cnt <= frame_cnt + 11'd1;

         if (seq_load) begin
            pend_v <= 1'b1;
            pend_a <= seq_a;
            pend_d <= seq_d;
         end else if (pend_issue) begin
            pend_v <= 1'b0;
         end
      end
   end

   always_comb begin
      tmr_io_we = 1'b0;
      tmr_io_a  = 6'h00;
      tmr_io_di = 8'h00;
      if (cpu_fwd) begin
         tmr_io_we = 1'b1;
         tmr_io_a  = cpu_io_a;
         tmr_io_di = cpu_io_di;
      end else if (pend_issue) begin
         tmr_io_we = 1'b1;
         tmr_io_a  = pend_a;
         tmr_io_di = pend_d;
      end
   end

   always_comb begin
      cpu_io_do = tmr_io_do;
      unique case (1'b1)
         sel_ctrl: cpu_io_do = {6'b0, blocked, en};
         sel_perl: cpu_io_do = period[7:0];
         sel_perh: cpu_io_do = period[15:8];
         sel_frml: cpu_io_do = frame_cnt[7:0];
         sel_frmh: cpu_io_do = {5'b0, frame_cnt[10:8]};
         default:  cpu_io_do = tmr_io_do;
      endcase
   end

   assign cpu_irq     = {tmr_irq[1], tmr_irq[0] & ~in_run};
   assign tmr_irq_ack = {cpu_irq_ack[1],
                         ack_q | (cpu_irq_ack[0] & ~in_run)};
   assign sof         = sof_q;
   assign frame_no    = frame_cnt;

endmodule
